// File: rtl/dmi_buffer.sv
// DTM-to-DM decoupling buffer: request/response FIFOs with response-space reservation and DTM clear.
// Optional response watchdog enabled by defining DMI_BUF_TIMEOUT_EN.
module dmi_buffer #(
    parameter int unsigned ReqDepth      = 2,
    parameter int unsigned RespDepth     = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dtm_clear,
    input  logic                           dtm_req_valid,
    output logic                           dtm_req_ready,
    input  logic [40:0]                    dtm_req,
    output logic                           dtm_resp_valid,
    input  logic                           dtm_resp_ready,
    output logic [33:0]                    dtm_resp,
    output logic                           dm_req_valid,
    input  logic                           dm_req_ready,
    output logic [40:0]                    dm_req,
    input  logic                           dm_resp_valid,
    output logic                           dm_resp_ready,
    input  logic [33:0]                    dm_resp,
    output logic [$clog2(RespDepth+1)-1:0] outstanding,
    output logic [$clog2(RespDepth+1)-1:0] drop_count,
    output logic                           timeout_event
);

    localparam int unsigned CW    = $clog2(RespDepth + 1);
    localparam int unsigned SW    = CW + 2;
    localparam int unsigned RQ_CW = $clog2(ReqDepth + 1);
    localparam int unsigned RQ_PW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int unsigned RS_PW = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    // request FIFO
    logic [40:0]      req_mem [ReqDepth];
    logic [RQ_PW-1:0] req_rd_ptr;
    logic [RQ_PW-1:0] req_wr_ptr;
    logic [RQ_CW-1:0] req_count;
    logic             req_full;
    logic             req_empty;
    logic             req_push;
    logic             req_pop;

    // response FIFO
    logic [33:0]      resp_mem [RespDepth];
    logic [RS_PW-1:0] resp_rd_ptr;
    logic [RS_PW-1:0] resp_wr_ptr;
    logic [CW-1:0]    resp_count;
    logic             resp_full;
    logic             resp_empty;
    logic             resp_push;
    logic             resp_pop;
    logic [33:0]      resp_push_data;

    logic             resp_take;
    logic             resp_drop;
    logic             timeout_fire;
    logic [SW-1:0]    budget_used;
    logic             issue_ok;

    always_comb begin
        req_full   = (req_count == RQ_CW'(ReqDepth));
        req_empty  = (req_count == '0);
        resp_full  = (resp_count == CW'(RespDepth));
        resp_empty = (resp_count == '0);

        budget_used = SW'(outstanding) + SW'(drop_count) + SW'(resp_count);
        issue_ok    = (budget_used < SW'(RespDepth));

        dtm_req_ready  = !rst && !req_full && !dtm_clear;
        dm_req_valid   = !rst && !req_empty && !dtm_clear && issue_ok;
        dm_req         = req_mem[req_rd_ptr];
        dtm_resp_valid = !rst && !resp_empty;
        dtm_resp       = resp_mem[resp_rd_ptr];
        dm_resp_ready  = 1'b1;

        req_push = dtm_req_valid && dtm_req_ready;
        req_pop  = dm_req_valid && dm_req_ready;

        resp_take = dm_resp_valid && !dtm_clear && (drop_count == '0);
        resp_drop = dm_resp_valid && !dtm_clear && (drop_count != '0);
        resp_push = resp_take || timeout_fire;
        resp_pop  = dtm_resp_valid && dtm_resp_ready;

        resp_push_data = resp_take ? dm_resp : {32'h0, 2'd2};
    end

    always_ff @(posedge clk) begin
        if (req_push) begin
            req_mem[req_wr_ptr] <= dtm_req;
        end
        if (resp_push) begin
            resp_mem[resp_wr_ptr] <= resp_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || dtm_clear) begin
            req_rd_ptr  <= '0;
            req_wr_ptr  <= '0;
            req_count   <= '0;
            resp_rd_ptr <= '0;
            resp_wr_ptr <= '0;
            resp_count  <= '0;
        end else begin
            if (req_push) begin
                req_wr_ptr <= (req_wr_ptr == RQ_PW'(ReqDepth - 1)) ? '0 : req_wr_ptr + 1'b1;
            end
            if (req_pop) begin
                req_rd_ptr <= (req_rd_ptr == RQ_PW'(ReqDepth - 1)) ? '0 : req_rd_ptr + 1'b1;
            end
            req_count <= req_count + RQ_CW'(req_push) - RQ_CW'(req_pop);

            if (resp_push) begin
                resp_wr_ptr <= (resp_wr_ptr == RS_PW'(RespDepth - 1)) ? '0 : resp_wr_ptr + 1'b1;
            end
            if (resp_pop) begin
                resp_rd_ptr <= (resp_rd_ptr == RS_PW'(RespDepth - 1)) ? '0 : resp_rd_ptr + 1'b1;
            end
            resp_count <= resp_count + CW'(resp_push) - CW'(resp_pop);
        end
    end

    // On clear every in-flight request becomes a response to be discarded;
    // a response arriving in the clear cycle itself is already accounted for.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop_count  <= '0;
        end else if (dtm_clear) begin
            outstanding <= '0;
            drop_count  <= outstanding + drop_count - CW'(dm_resp_valid);
        end else begin
            outstanding <= outstanding + CW'(req_pop) - CW'(resp_take) - CW'(timeout_fire);
            drop_count  <= drop_count - CW'(resp_drop) + CW'(timeout_fire);
        end
    end

`ifdef DMI_BUF_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TimeoutCycles);

    logic [WW-1:0] wd_count;
    logic          wd_run;

    always_comb begin
        wd_run        = !rst && (outstanding != '0) && !dm_resp_valid && !dtm_clear;
        timeout_fire  = wd_run && (wd_count == WW'(TimeoutCycles - 1));
        timeout_event = timeout_fire;
    end

    always_ff @(posedge clk) begin
        if (rst || !wd_run || timeout_fire) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 1'b1;
        end
    end
`else
    always_comb begin
        timeout_fire  = 1'b0;
        timeout_event = 1'b0;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (ReqDepth >= 1 && RespDepth >= 1 && TimeoutCycles >= 2);
        if (!rst) begin
            assert (!(resp_push && resp_full && !resp_pop));
            assert (!(resp_take && outstanding == '0));
            assert (!(dtm_clear && dm_resp_valid && outstanding == '0 && drop_count == '0));
            assert (SW'(outstanding) + SW'(resp_count) <= SW'(RespDepth));
`ifndef DMI_BUF_TIMEOUT_EN
            // a synthetic timeout response is briefly counted in both drop_count and resp_count
            assert (budget_used <= SW'(RespDepth));
`endif
        end
    end
`endif

endmodule

// File: tb/tb_dmi_buffer.sv
// Table-driven check of dmi_buffer (ReqDepth=2, RespDepth=2, TimeoutCycles=16)
// plus a watchdog sequence whose expectation depends on DMI_BUF_TIMEOUT_EN.
module tb_dmi_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dtm_clear;
    logic        dtm_req_valid;
    logic        dtm_req_ready;
    logic [40:0] dtm_req;
    logic        dtm_resp_valid;
    logic        dtm_resp_ready;
    logic [33:0] dtm_resp;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [40:0] dm_req;
    logic        dm_resp_valid;
    logic        dm_resp_ready;
    logic [33:0] dm_resp;
    logic [1:0]  outstanding;
    logic [1:0]  drop_count;
    logic        timeout_event;

    int total = 0;
    int bad   = 0;

    dmi_buffer #(.ReqDepth(2), .RespDepth(2), .TimeoutCycles(16)) dut (
        .clk(clk), .rst(rst), .dtm_clear(dtm_clear),
        .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req(dtm_req),
        .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready), .dtm_resp(dtm_resp),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req(dm_req),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready), .dm_resp(dm_resp),
        .outstanding(outstanding), .drop_count(drop_count), .timeout_event(timeout_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, clr, rqv;
        logic [40:0] rq;
        logic        rsr, dmr, dmv;
        logic [33:0] dmrs;
        logic        e_rqr, e_dmv;
        logic [40:0] e_dmrq;
        logic        e_rsv;
        logic [33:0] e_rs;
        logic [1:0]  e_out, e_drop;
    } vec_t;

    localparam logic        L  = 1'b0;
    localparam logic        H  = 1'b1;
    localparam logic [40:0] NQ = '0;
    localparam logic [33:0] NR = '0;

    vec_t vq[$];

    function automatic logic [40:0] rd(input logic [6:0] a);
        return {a, 2'd1, 32'h0};
    endfunction

    function automatic logic [33:0] rs(input logic [31:0] d);
        return {d, 2'd0};
    endfunction

    function automatic vec_t mk(input logic r, c, qv, input logic [40:0] q,
                                input logic sr, dr, dv, input logic [33:0] ds,
                                input logic eqr, edv, input logic [40:0] edq,
                                input logic esv, input logic [33:0] es,
                                input logic [1:0] eo, ed);
        vec_t v;
        v.rst = r; v.clr = c; v.rqv = qv; v.rq = q;
        v.rsr = sr; v.dmr = dr; v.dmv = dv; v.dmrs = ds;
        v.e_rqr = eqr; v.e_dmv = edv; v.e_dmrq = edq;
        v.e_rsv = esv; v.e_rs = es; v.e_out = eo; v.e_drop = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; dtm_clear = 1'b0; dtm_req_valid = 1'b0; dtm_req = '0;
        dtm_resp_ready = 1'b0; dm_req_ready = 1'b1; dm_resp_valid = 1'b0; dm_resp = '0;
    endtask

    initial begin
        int hit;
        // reset idle
        vq.push_back(mk(H,L,L,NQ,               H,H,L,NR,               L,L,NQ,L,NR,2'd0,2'd0));
        // in-order write then read, DM always ready
        vq.push_back(mk(L,L,H,{7'h10,2'd2,32'h1},H,H,L,NR,              H,L,NQ,L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h11),        H,H,L,NR,               H,H,{7'h10,2'd2,32'h1},L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,H,rd(7'h11),L,NR,2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,H,rs(32'hABCD_0000),H,L,NQ,L,NR,2'd2,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,H,rs(32'h1234_5678),H,L,NQ,H,rs(32'hABCD_0000),2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,H,rs(32'h1234_5678),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        // four reads against a stalled DTM response side
        vq.push_back(mk(L,L,H,rd(7'h20),        L,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h21),        L,H,L,NR,               H,H,rd(7'h20),L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h22),        L,H,L,NR,               H,H,rd(7'h21),L,NR,2'd1,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h23),        L,H,L,NR,               H,L,NQ,L,NR,2'd2,2'd0));
        vq.push_back(mk(L,L,L,NQ,               L,H,H,rs(32'hB1),       L,L,NQ,L,NR,2'd2,2'd0));
        vq.push_back(mk(L,L,L,NQ,               L,H,H,rs(32'hB2),       L,L,NQ,H,rs(32'hB1),2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               L,H,L,NR,               L,L,NQ,H,rs(32'hB1),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               L,L,NQ,H,rs(32'hB1),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               L,H,L,NR,               L,H,rd(7'h22),H,rs(32'hB2),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               L,H,H,rs(32'hB3),       H,L,NQ,H,rs(32'hB2),2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,H,rs(32'hB2),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,H,rd(7'h23),H,rs(32'hB3),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,H,rs(32'hB4),       H,L,NQ,L,NR,2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,H,rs(32'hB4),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        // clear with two in flight and one queued; two late responses dropped
        vq.push_back(mk(L,L,H,rd(7'h30),        H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h31),        H,H,L,NR,               H,H,rd(7'h30),L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h3F),        H,H,L,NR,               H,H,rd(7'h31),L,NR,2'd1,2'd0));
        vq.push_back(mk(L,H,L,NQ,               H,H,L,NR,               L,L,NQ,L,NR,2'd2,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h32),        H,H,H,rs(32'hDEAD_0001),H,L,NQ,L,NR,2'd0,2'd2));
        vq.push_back(mk(L,L,L,NQ,               H,H,H,rs(32'hDEAD_0002),H,H,rd(7'h32),L,NR,2'd0,2'd1));
        vq.push_back(mk(L,L,L,NQ,               H,H,H,rs(32'hC3C3_C3C3),H,L,NQ,L,NR,2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,H,rs(32'hC3C3_C3C3),2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        // clear coincident with the only response
        vq.push_back(mk(L,L,H,rd(7'h40),        H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,H,rd(7'h40),L,NR,2'd0,2'd0));
        vq.push_back(mk(L,H,L,NQ,               H,H,H,rs(32'h0D0D_0D0D),L,L,NQ,L,NR,2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        // reset with one queued request and one queued response
        vq.push_back(mk(L,L,H,rd(7'h50),        L,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h51),        L,H,L,NR,               H,H,rd(7'h50),L,NR,2'd0,2'd0));
        vq.push_back(mk(L,L,H,rd(7'h52),        L,H,H,rs(32'hE5),       H,H,rd(7'h51),L,NR,2'd1,2'd0));
        vq.push_back(mk(H,L,L,NQ,               L,H,L,NR,               L,L,NQ,L,NR,2'd1,2'd0));
        vq.push_back(mk(L,L,L,NQ,               H,H,L,NR,               H,L,NQ,L,NR,2'd0,2'd0));

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vq[i]) begin
            rst = vq[i].rst; dtm_clear = vq[i].clr;
            dtm_req_valid = vq[i].rqv; dtm_req = vq[i].rq;
            dtm_resp_ready = vq[i].rsr; dm_req_ready = vq[i].dmr;
            dm_resp_valid = vq[i].dmv; dm_resp = vq[i].dmrs;
            @(negedge clk);
            chk($sformatf("row%0d dtm_req_ready", i), 64'(dtm_req_ready), 64'(vq[i].e_rqr));
            chk($sformatf("row%0d dm_req_valid", i), 64'(dm_req_valid), 64'(vq[i].e_dmv));
            if (vq[i].e_dmv)
                chk($sformatf("row%0d dm_req", i), 64'(dm_req), 64'(vq[i].e_dmrq));
            chk($sformatf("row%0d dtm_resp_valid", i), 64'(dtm_resp_valid), 64'(vq[i].e_rsv));
            if (vq[i].e_rsv)
                chk($sformatf("row%0d dtm_resp", i), 64'(dtm_resp), 64'(vq[i].e_rs));
            chk($sformatf("row%0d outstanding", i), 64'(outstanding), 64'(vq[i].e_out));
            chk($sformatf("row%0d drop_count", i), 64'(drop_count), 64'(vq[i].e_drop));
            chk($sformatf("row%0d dm_resp_ready", i), 64'(dm_resp_ready), 64'(1));
            chk($sformatf("row%0d timeout_event", i), 64'(timeout_event), 64'(0));
            cyc();
        end

        // watchdog: one read, DM stays silent
        idle();
        dtm_req_valid = 1'b1; dtm_req = rd(7'h60);
        cyc();
        dtm_req_valid = 1'b0;
        @(negedge clk);
        chk("wd issue valid", 64'(dm_req_valid), 64'(1));
        cyc();
        hit = 0;
        for (int n = 1; n <= 40 && hit == 0; n++) begin
            @(negedge clk);
            if (timeout_event) hit = n;
            else cyc();
        end
`ifdef DMI_BUF_TIMEOUT_EN
        chk("wd expiry cycle", 64'(hit), 64'(16));
        cyc();
        @(negedge clk);
        chk("wd synth valid", 64'(dtm_resp_valid), 64'(1));
        chk("wd synth resp", 64'(dtm_resp), 64'({32'h0, 2'd2}));
        chk("wd outstanding", 64'(outstanding), 64'(0));
        chk("wd drop_count", 64'(drop_count), 64'(1));
        dtm_resp_ready = 1'b1;
        cyc();
        dtm_resp_ready = 1'b0;
        repeat (19) cyc();
        dm_resp_valid = 1'b1; dm_resp = rs(32'h6060_6060);
        cyc();
        dm_resp_valid = 1'b0;
        @(negedge clk);
        chk("wd late dropped", 64'(dtm_resp_valid), 64'(0));
        chk("wd late drop_count", 64'(drop_count), 64'(0));
`else
        chk("wd never fires", 64'(hit), 64'(0));
        chk("wd outstanding held", 64'(outstanding), 64'(1));
        cyc();
        dm_resp_valid = 1'b1; dm_resp = rs(32'h6060_6060);
        cyc();
        dm_resp_valid = 1'b0;
        @(negedge clk);
        chk("wd late valid", 64'(dtm_resp_valid), 64'(1));
        chk("wd late resp", 64'(dtm_resp), 64'(rs(32'h6060_6060)));
        chk("wd late outstanding", 64'(outstanding), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
